// File: rtl/ice40_regfile_mp.sv
// ice40_regfile_mp: parametrised multi-read-port register file for iCE40
// soft cores. One EBR-style array copy per read port, every write fans out
// to all copies. A post-reset clear sequencer fills every entry with
// INIT_VAL before `ready` rises; the core stalls on `ready`.
//
// Optional feature macro: ICE40_REGFILE_BYPASS_EN
//   defined   -> same-edge write/read of one address returns the new data
//                (write-first), via a registered compare and output mux.
//   undefined -> native EBR read-first behaviour, no bypass logic.

// ---------------------------------------------------------------------------
// One read port: a full array copy, its read register and output shaping.
// ---------------------------------------------------------------------------
module ice40_regfile_bank #(
    parameter int DW      = 32,
    parameter int AW      = 6,
    parameter int ZERO_R0 = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ready,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_wa,
    input  logic [DW-1:0] mem_wd,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] raw_q;
    logic          zero_q;
    logic          byp_q;
    logic [DW-1:0] byp_data_q;

    // Array write plus read-first synchronous read; kept reset-free so it
    // maps onto EBR.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        raw_q <= mem[raddr];
    end

    // Remember whether the sampled address is the hard-wired zero register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= (ZERO_R0 != 0) && (raddr == '0);
        end
    end

`ifdef ICE40_REGFILE_BYPASS_EN
    // Capture a same-edge user write hit so the new data wins over the
    // stale EBR read. mem_we already excludes discarded writes to r0, and
    // `ready` keeps clear-sequencer writes out of the bypass path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q      <= ready && mem_we && (mem_wa == raddr);
            byp_data_q <= mem_wd;
        end
    end
`else
    assign byp_q      = 1'b0;
    assign byp_data_q = '0;
`endif

    // Output is forced to zero until clearing is done and for r0 reads.
    assign rdata = (!ready || zero_q) ? '0 : (byp_q ? byp_data_q : raw_q);

endmodule

// ---------------------------------------------------------------------------
// Top: clear sequencer / write steering, one bank per read port (NRP 1..4).
// ---------------------------------------------------------------------------
module ice40_regfile_mp #(
    parameter int          DW       = 32,
    parameter int          AW       = 6,
    parameter int          NRP      = 2,
    parameter int          ZERO_R0  = 1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              wen,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [NRP*AW-1:0] raddr,
    output logic [NRP*DW-1:0] rdata
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    // One extra bit so completion shows up as the carry out of the last
    // address rather than a wrap back to zero.
    logic [AW:0]   cnt_q, cnt_d;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    // State and clear-counter registers; reset restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and the single write port shared by all array copies:
    // sequencer owns it in CLEAR, the user owns it in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_wa  = waddr;
        mem_wd  = wdata;
        unique case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt_q[AW-1:0];
                mem_wd = INIT_VAL;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_d[AW]) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_we = wen && !((ZERO_R0 != 0) && (waddr == '0));
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign ready = (state_q == RUN);

    for (genvar k = 0; k < NRP; k++) begin : g_port
        ice40_regfile_bank #(
            .DW      (DW),
            .AW      (AW),
            .ZERO_R0 (ZERO_R0)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .ready  (ready),
            .mem_we (mem_we),
            .mem_wa (mem_wa),
            .mem_wd (mem_wd),
            .raddr  (raddr[k*AW +: AW]),
            .rdata  (rdata[k*DW +: DW])
        );
    end

endmodule
